seg_scan: RTL and testbench

- Multiplexed 4-digit 7-segment display driver; the output-side counterpart of the keypad row scanner.
- Holds a 16-bit hex/BCD value and drives one active-low digit select at a time, with active-low segments and decimal point.
- Loaded by calculator/stopwatch control logic. New values are applied only at frame boundaries, so the display never shows a torn value.

---
 rtl/seg_pkg.sv | 39 +++
 rtl/seg_scan_if.sv | 27 ++
 rtl/seg_decoder.sv | 13 +
 rtl/seg_scan.sv | 132 +++++++++++++
 tb/tb_seg_scan.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seg_scan display driver.
//   GLYPH     - active-low gfedcba patterns, indexed by the 4-bit code
//   DIGIT_SEL - active-low digit enable pattern, indexed by digit slot
//   SEG_OFF / SEL_OFF - all segments / all digits dark
//   phase_e   - per-slot phase (blanking gap vs. digit shown)
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] SEL_OFF = 4'hF;

    // Concatenation lists code F first so that GLYPH[code] selects the glyph for code.
    localparam logic [15:0][6:0] GLYPH = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Digit 0 is the leftmost digit.
    localparam logic [3:0][3:0] DIGIT_SEL = {4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_e;

endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: load side and display side of the seg_scan driver.
//   load, value_in[15:0], dp_in[3:0]   - value capture from the control logic
//   digit_sel[3:0], seg[6:0], dp       - active-low display drive
//   pending, frame_done                - status back to the control logic
// master: control logic side; slave: the display driver.
interface seg_scan_if;

    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_sel;
    logic [6:0]  seg;
    logic        dp;
    logic        pending;
    logic        frame_done;

    modport master (
        output load, value_in, dp_in,
        input  digit_sel, seg, dp, pending, frame_done
    );

    modport slave (
        input  load, value_in, dp_in,
        output digit_sel, seg, dp, pending, frame_done
    );

endinterface

// File: rtl/seg_decoder.sv
// seg_decoder: combinational 4-bit code to active-low gfedcba glyph.
//   code[3:0]  - hex digit to display
//   glyph[6:0] - active-low segment pattern from seg_pkg::GLYPH
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] glyph
);

    assign glyph = GLYPH[code];

endmodule

// File: rtl/seg_scan.sv
// seg_scan: multiplexed 4-digit 7-segment display driver.
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - seg_scan_if.slave: load/value_in/dp_in in; digit_sel/seg/dp/pending/frame_done out
// A shadow register takes loads at any time; it is copied into the displayed
// value only at the frame boundary, so a frame never mixes two values.
// Optional build macro SEG_SCAN_LEADING_ZERO_BLANK_EN blanks leading zero
// digits 0..2 (decimal points stay visible; digit 3 always shows).
//
// phase     | meaning
// PH_BLANK  | first BLANK_CYCLES of a slot, all digits dark (anti-ghosting)
// PH_SHOW   | rest of the slot, digit idx driven with its glyph and dp
module seg_scan
    import seg_pkg::*;
#(
    parameter int CLOCK_FREQ   = 50000000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic      clk,
    input  logic      rst,
    seg_scan_if.slave bus
);

    localparam int DIV = CLOCK_FREQ / REFRESH_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   shadow_val;
    logic [3:0]    shadow_dp;
    logic [15:0]   active_val;
    logic [3:0]    active_dp;
    logic          pending_q;
    logic          frame_done_q;
    logic [3:0]    digit_sel_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    phase_e        phase;
    logic [3:0]    code;
    logic [6:0]    glyph;
    logic          dp_bit;
    logic          lz_blank;
    logic          boundary;

    always_comb begin
        phase    = (cnt < BLANK_END) ? PH_BLANK : PH_SHOW;
        boundary = (cnt == CNT_LAST) && (idx == 2'd3);
        // dp_in[3] belongs to digit 0, so the bit index is the inverted slot number.
        dp_bit   = active_dp[~idx];
        case (idx)
            2'd0:    code = active_val[15:12];
            2'd1:    code = active_val[11:8];
            2'd2:    code = active_val[7:4];
            default: code = active_val[3:0];
        endcase
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        case (idx)
            2'd0:    lz_blank = (active_val[15:12] == 4'h0);
            2'd1:    lz_blank = (active_val[15:8] == 8'h00);
            2'd2:    lz_blank = (active_val[15:4] == 12'h000);
            default: lz_blank = 1'b0;
        endcase
`else
        lz_blank = 1'b0;
`endif
    end

    seg_decoder u_decoder (
        .code  (code),
        .glyph (glyph)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= 2'd0;
            shadow_val   <= 16'h0000;
            shadow_dp    <= 4'h0;
            active_val   <= 16'h0000;
            active_dp    <= 4'h0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            digit_sel_q  <= SEL_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            // The boundary copy uses the shadow as it was before any same-cycle
            // load, so a colliding load waits for the next boundary.
            if (boundary && pending_q) begin
                active_val <= shadow_val;
                active_dp  <= shadow_dp;
            end
            if (bus.load) begin
                shadow_val <= bus.value_in;
                shadow_dp  <= bus.dp_in;
                pending_q  <= 1'b1;
            end else if (boundary) begin
                pending_q  <= 1'b0;
            end

            frame_done_q <= boundary;

            if (phase == PH_SHOW) begin
                digit_sel_q <= DIGIT_SEL[idx];
                seg_q       <= lz_blank ? SEG_OFF : glyph;
                dp_q        <= ~dp_bit;
            end else begin
                digit_sel_q <= SEL_OFF;
                seg_q       <= SEG_OFF;
                dp_q        <= 1'b1;
            end
        end
    end

    assign bus.digit_sel  = digit_sel_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: self-checking bench for seg_scan (DIV=10, BLANK_CYCLES=2).
// Expected frames are queued when a value is loaded and compared by a
// monitor that captures each displayed frame digit by digit.
module tb_seg_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_if bus ();

    seg_scan #(
        .CLOCK_FREQ   (40),
        .REFRESH_HZ   (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    // Frame expectations: seg_exp = {digit0, digit1, digit2, digit3}, dp_exp[3] = digit 0.
    localparam logic [27:0] ZERO_SEG = LZ ? {7'h7F, 7'h7F, 7'h7F, 7'h40}
                                          : {7'h40, 7'h40, 7'h40, 7'h40};

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          frame;
        logic [27:0] seg_exp;
        logic [3:0]  dp_exp;
        string       tag;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dpin;
        logic [27:0] seg_exp;
        logic [3:0]  dp_exp;
    } vec_t;

    int         fcount   = 0;
    int         mon_d;
    logic [3:0] prev_sel = 4'hF;
    logic [6:0] cap_seg [4];
    logic [3:0] cap_dp   = 4'hF;
    logic [3:0] cap_mask = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int frame, input logic [27:0] s, input logic [3:0] d, input string tag);
        exp_t e;
        e.frame   = frame;
        e.seg_exp = s;
        e.dp_exp  = d;
        e.tag     = tag;
        sb.push_back(e);
    endtask

    task automatic compare_frame();
        exp_t e;
        while (sb.size() > 0 && sb[0].frame < fcount) begin
            check({sb[0].tag, " frame_missed"}, fcount, sb[0].frame);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].frame == fcount) begin
            e = sb.pop_front();
            check({e.tag, " frame_complete"}, cap_mask, 4'hF);
            for (int d = 0; d < 4; d++)
                check($sformatf("%s seg_d%0d", e.tag, d), cap_seg[d], e.seg_exp[27-7*d -: 7]);
            check({e.tag, " dp"}, cap_dp, e.dp_exp);
        end
    endtask

    // Monitor: frame counter plus capture of the first SHOW sample of each slot.
    always @(negedge clk) begin
        if (rst) begin
            prev_sel = 4'hF;
            cap_mask = 4'h0;
        end else begin
            if (bus.frame_done) fcount++;
            if (bus.digit_sel != 4'hF && prev_sel == 4'hF) begin
                case (bus.digit_sel)
                    4'b0111: mon_d = 0;
                    4'b1011: mon_d = 1;
                    4'b1101: mon_d = 2;
                    4'b1110: mon_d = 3;
                    default: mon_d = -1;
                endcase
                if (mon_d < 0) begin
                    check("digit_sel_pattern", bus.digit_sel, 4'b0111);
                end else begin
                    cap_seg[mon_d]  = bus.seg;
                    cap_dp[3-mon_d] = bus.dp;
                    if (mon_d == 0) cap_mask = 4'b0001;
                    else            cap_mask[mon_d] = 1'b1;
                    if (mon_d == 3) compare_frame();
                end
            end
            prev_sel = bus.digit_sel;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_pulse(input string name);
        int k = 0;
        do begin
            step();
            k++;
        end while (!bus.frame_done && k < 100);
        check(name, bus.frame_done, 1'b1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bus.load     = 1'b1;
        bus.value_in = v;
        bus.dp_in    = d;
        step();
        bus.load     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       vecs [6];
        logic [3:0] rel_sel [14];
        int         f;

        vecs[0] = '{16'h1234, 4'b0100, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1011};
        vecs[1] = '{16'h0070, 4'b0000,
                    LZ ? {7'h7F, 7'h7F, 7'h78, 7'h40} : {7'h40, 7'h40, 7'h78, 7'h40}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0010,
                    LZ ? {7'h7F, 7'h7F, 7'h7F, 7'h40} : {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1101};
        vecs[3] = '{16'h89EF, 4'b1001, {7'h00, 7'h10, 7'h06, 7'h0E}, 4'b0110};
        vecs[4] = '{16'h5AB6, 4'b1111, {7'h12, 7'h08, 7'h03, 7'h02}, 4'b0000};
        vecs[5] = '{16'h0C07, 4'b0000,
                    LZ ? {7'h7F, 7'h46, 7'h40, 7'h78} : {7'h40, 7'h46, 7'h40, 7'h78}, 4'b1111};

        rel_sel = '{4'hF, 4'hF, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7,
                    4'hF, 4'hF, 4'hB};

        bus.load     = 1'b0;
        bus.value_in = 16'h0000;
        bus.dp_in    = 4'h0;

        // Reset state and release sequence.
        repeat (3) @(negedge clk);
        #1;
        check("rst_sel", bus.digit_sel, 4'hF);
        check("rst_seg", bus.seg, 7'h7F);
        check("rst_dp", bus.dp, 1'b1);
        check("rst_pending", bus.pending, 1'b0);
        check("rst_frame_done", bus.frame_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        push_exp(fcount, ZERO_SEG, 4'hF, "reset_zero");
        #1;
        for (int s = 0; s <= 80; s++) begin
            if (s <= 13) check($sformatf("release_sel_s%0d", s), bus.digit_sel, rel_sel[s]);
            else         check($sformatf("release_fd_s%0d", s), bus.frame_done, (s == 40 || s == 80));
            if (s < 80) begin
                @(negedge clk);
                #1;
            end
        end

        // Load mid-frame, apply at boundary, for each vector.
        wait_pulse("pulse_start");
        foreach (vecs[i]) begin
            repeat (5) step();
            push_exp(fcount + 1, vecs[i].seg_exp, vecs[i].dp_exp, $sformatf("vec%0d", i));
            do_load(vecs[i].value, vecs[i].dpin);
            check($sformatf("vec%0d pend_set", i), bus.pending, 1'b1);
            repeat (33) step();
            check($sformatf("vec%0d pend_hold", i), bus.pending, 1'b1);
            step();
            check($sformatf("vec%0d fd_period", i), bus.frame_done, 1'b1);
            check($sformatf("vec%0d pend_clr", i), bus.pending, 1'b0);
        end

        // Two loads in one frame (last wins), then a load on the boundary cycle.
        repeat (5) step();
        do_load(16'h1111, 4'h0);
        do_load(16'h5555, 4'h0);
        repeat (32) step();
        f = fcount;
        push_exp(f + 1, {7'h12, 7'h12, 7'h12, 7'h12}, 4'hF, "coll_5555");
        push_exp(f + 2, {7'h08, 7'h03, 7'h46, 7'h21}, 4'h0, "coll_ABCD");
        bus.load     = 1'b1;
        bus.value_in = 16'hABCD;
        bus.dp_in    = 4'hF;
        step();
        bus.load     = 1'b0;
        check("coll_fd", bus.frame_done, 1'b1);
        check("coll_pend_kept", bus.pending, 1'b1);
        repeat (40) step();
        check("coll_fd2", bus.frame_done, 1'b1);
        check("coll_pend_clr", bus.pending, 1'b0);

        // Asynchronous reset during a SHOW slot with a value pending.
        wait_pulse("pulse_before_rst");
        repeat (5) step();
        do_load(16'h9999, 4'hF);
        check("pre_rst_pending", bus.pending, 1'b1);
        repeat (4) step();
        check("pre_rst_sel", bus.digit_sel, 4'b0111);
        #1 rst = 1'b1;
        #1;
        check("async_rst_sel", bus.digit_sel, 4'hF);
        check("async_rst_seg", bus.seg, 7'h7F);
        check("async_rst_dp", bus.dp, 1'b1);
        check("async_rst_pending", bus.pending, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push_exp(fcount, ZERO_SEG, 4'hF, "after_rst");
        #1;
        check("after_rst_sel0", bus.digit_sel, 4'hF);
        repeat (3) @(negedge clk);
        #1;
        check("after_rst_sel3", bus.digit_sel, 4'b0111);
        check("after_rst_seg3", bus.seg, LZ ? 7'h7F : 7'h40);
        repeat (50) step();
        check("after_rst_pending", bus.pending, 1'b0);
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
